rd_return_receiver: RTL and testbench
=====================================

# rd_return_receiver

Per-core receiver on the dedicated read-data return path driven by the coherent memory mux (`RDreturn`/`RDdest`). It snoops every cycle for words tagged with this core's ID and assembles them into cache lines of `WORDS_PER_LINE` words. Complete lines go into a small line FIFO and are handed to the core's cache over a valid/ready handshake. The block also issues read-request credits so the core never has more lines in flight than the FIFO can absorb.

## Interface
- `CORE_ID`, 1: 4-bit ring ID of this core. Must be non-zero; ID 0 marks an idle return slot.
- `WORDS_PER_LINE`, 8: 32-bit words per returned line. Power of two, 2–16.
- `LINE_DEPTH`, 2: line FIFO depth in lines, 1–8.

- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `RDreturn`  in  32  read-return data word from the memory mux.
- `RDdest`  in  4  destination ID of `RDreturn`. A value of 0 means no word this cycle.
- `reqIssue`  in  1  one-cycle pulse: core placed a read `Address` on the ring.
- `canIssue`  out  1  credit available; core may pulse `reqIssue` next.
- `lineValid`  out  1  head of the line FIFO is valid.
- `lineData`  out  32*WORDS_PER_LINE  head line. Word 0 is in bits [31:0], word k in [32k+31:32k].
- `lineReady`  in  1  cache accepts the head line when `lineValid & lineReady`.
- `outstanding`  out  4  read requests issued whose last word has not yet arrived.
- `overflow`  out  1  sticky: a completed line was dropped because the FIFO was full.
- `spurious`  out  1  sticky: a matching word arrived while `outstanding == 0`.
- `protoErr`  out  1  sticky: `reqIssue` was asserted while `canIssue == 0`.

## Operation
- **Match:** `hit = (RDdest == CORE_ID)`. Words with any other dest, including 0, are ignored.
- **Assembly:**
  - On each `hit`, `RDreturn` is written into assembly slot `wcnt` and `wcnt` increments.
  - `wcnt` is log2(WORDS_PER_LINE) bits wide and wraps to 0 after the last word.
  - Words of one line need not be contiguous; other dests may interleave idle cycles.
- **Line complete:** `done = hit & (wcnt == WORDS_PER_LINE-1)`. On `done`:
  - push the assembled line, including the current word, into the FIFO;
  - `outstanding` decrements (saturating at 0).
- **Outstanding counter:** increments on `reqIssue`, saturating at 15. When `reqIssue` and `done` occur in the same cycle, `outstanding` is unchanged.
- **Credit:** `canIssue = (outstanding + occ) < LINE_DEPTH`, where `occ` is the FIFO occupancy (0..LINE_DEPTH). Use a 5-bit sum.
- **FIFO:**
  - Pop on `lineValid & lineReady`.
  - A push succeeds if `occ < LINE_DEPTH`, or if a pop happens in the same cycle.
  - Otherwise the line is dropped, `overflow` is set, and `occ` is unchanged.
  - Simultaneous successful push and pop leave `occ` unchanged.
- **Error flags:**
  - `spurious` is set when `hit` occurs with `outstanding == 0`. The word is still captured.
  - `protoErr` is set when `reqIssue` occurs with `canIssue == 0`. `outstanding` still increments.
  - All sticky flags clear only on `reset`.
- **Reset:** while `reset` is high, a partially assembled line is discarded, `wcnt` returns to 0, and the FIFO empties.

## Timing
- **Reset values:** `lineValid=0`, `lineData=0`, `outstanding=0`, `canIssue=1`, `overflow=0`, `spurious=0`, `protoErr=0`. Internal: `wcnt=0`, `occ=0`.
- **Capture:** a word is captured at the rising edge where `hit` is high. There is no input register stage.
- **Fill latency:** the last word lands at edge N; the line is pushed at edge N; `lineValid` is high and `lineData` is valid in the cycle after edge N (latency 1).
- **Output stability:** `lineData` is registered (FIFO head register) and stays stable while `lineValid & ~lineReady`.
- **Drain:** back-to-back pops are supported — one line per cycle while `lineValid & lineReady`.
- **Credit timing:**
  - `canIssue` is combinational from registered `outstanding` and `occ`, so it reflects updates one cycle after `reqIssue`, `done`, or a pop.
  - A `reqIssue` pulse in cycle t consumes a credit visible in cycle t+1.
- **Back-pressure:** none upstream. The return path cannot be stalled; correctness relies on the core honoring `canIssue`.

## Test plan
- **Single line:** `reqIssue` once, then 8 words `0x100..0x107` with `RDdest=CORE_ID` on consecutive cycles.
  - `lineValid` rises 1 cycle after word 7.
  - `lineData[31:0]=0x100`, `lineData[255:224]=0x107`.
  - `outstanding` goes 1→0.
- **Interleaved dests:** same 8 words, each separated by a cycle with `RDdest=0` or `RDdest=CORE_ID+1`.
  - Identical `lineData`.
  - Foreign words are never captured.
- **Credit limit:** with `LINE_DEPTH=2` and `lineReady=0`:
  - two `reqIssue` pulses drive `canIssue` to 0;
  - return both lines → `occ=2`, `canIssue=0`;
  - a single `lineReady` pop → `canIssue=1` next cycle.
- **Overflow:** `lineReady=0`, FIFO full (2 lines), then force a third line.
  - `overflow=1`, `occ` stays 2, head line unchanged.
  - Repeat with `lineReady=1` during the final word → no overflow, `occ` stays 2.
- **Errors:**
  - A matching word with `outstanding=0` → `spurious=1`.
  - `reqIssue` while `canIssue=0` → `protoErr=1`, `outstanding` still increments.
  - Both flags hold until `reset`.
- **Async reset mid-line:** assert `reset` after word 3 of a line, deassert, then send 8 fresh words.
  - Outputs return to their reset values immediately.
  - The new line contains only the fresh words, with word 0 at bits [31:0].

Source files
------------

// File: rtl/rd_return_receiver.sv
`default_nettype none
// ============================================================================
// Module   : rd_return_receiver
// Purpose  : Per-core read-return receiver. Snoops the read-data return
//            path for words tagged with this core's ID and assembles them
//            into cache lines. Completed lines are queued in a small line
//            FIFO and handed to the cache over valid/ready. Read-request
//            credits are issued so the lines in flight never exceed the
//            space the FIFO can absorb.
// Revision : 1.0 - initial release
// ============================================================================
module rd_return_receiver #(
  parameter int CORE_ID        = 1,  // non-zero; 0 marks an idle return slot
  parameter int WORDS_PER_LINE = 8,  // power of two, 2..16
  parameter int LINE_DEPTH     = 2   // 1..8 lines
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [31:0]                    RDreturn,
  input  logic [3:0]                     RDdest,
  input  logic                           reqIssue,
  output logic                           canIssue,
  output logic                           lineValid,
  output logic [32*WORDS_PER_LINE-1:0]   lineData,
  input  logic                           lineReady,
  output logic [3:0]                     outstanding,
  output logic                           overflow,
  output logic                           spurious,
  output logic                           protoErr
);

  localparam int                c_WCW    = $clog2(WORDS_PER_LINE);
  localparam int                c_LW     = 32 * WORDS_PER_LINE;
  localparam logic [c_WCW-1:0]  c_LAST   = c_WCW'(WORDS_PER_LINE - 1);
  localparam logic [3:0]        c_ID     = 4'(CORE_ID);
  localparam logic [3:0]        c_DEPTH  = 4'(LINE_DEPTH);
  localparam logic [4:0]        c_DEPTH5 = 5'(LINE_DEPTH);

  // Assembly state. The final word of a line is never stored here: it goes
  // straight from RDreturn into the FIFO on the completing edge.
  logic [c_WCW-1:0] r_wcnt;
  logic [31:0]      r_asm [WORDS_PER_LINE-1];
  logic [c_LW-1:0]  w_fullLine;

  // Line FIFO, organised as a shift register so the head (entry 0) is a
  // plain register output and lineData never passes through a read mux.
  logic [c_LW-1:0]  r_mem   [LINE_DEPTH];
  logic [c_LW-1:0]  w_shift [LINE_DEPTH];
  logic [3:0]       r_occ;
  logic [3:0]       w_wrIdx;

  logic [3:0]       r_out;
  logic             r_ovf;
  logic             r_spur;
  logic             r_proto;

  logic             w_hit;
  logic             w_done;
  logic             w_pop;
  logic             w_push;
  logic             w_room;

  assign w_hit   = (RDdest == c_ID);
  assign w_done  = w_hit && (r_wcnt == c_LAST);
  assign w_pop   = (r_occ != 4'd0) && lineReady;
  assign w_room  = (r_occ < c_DEPTH) || w_pop;
  assign w_push  = w_done && w_room;
  // With a simultaneous pop every entry moves down one, so the free slot
  // for the new line is one below the current occupancy.
  assign w_wrIdx = w_pop ? (r_occ - 4'd1) : r_occ;

  // Credit is derived from registered state only, so it reacts one cycle
  // after a request, a completed line or a pop.
  assign canIssue    = ({1'b0, r_out} + {1'b0, r_occ}) < c_DEPTH5;
  assign lineValid   = (r_occ != 4'd0);
  assign lineData    = r_mem[0];
  assign outstanding = r_out;
  assign overflow    = r_ovf;
  assign spurious    = r_spur;
  assign protoErr    = r_proto;

  // Word slot counter; the power-of-two line size makes it wrap by itself.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wcnt <= '0;
    end else if (w_hit) begin
      r_wcnt <= r_wcnt + 1'b1;
    end
  end

  for (genvar k = 0; k < WORDS_PER_LINE; k++) begin : g_slot
    if (k == WORDS_PER_LINE - 1) begin : g_last
      assign w_fullLine[32*k +: 32] = RDreturn;
    end else begin : g_body
      // Capture the matching word into its slot of the line being built.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_asm[k] <= '0;
        end else if (w_hit && (r_wcnt == c_WCW'(k))) begin
          r_asm[k] <= RDreturn;
        end
      end
      assign w_fullLine[32*k +: 32] = r_asm[k];
    end
  end

  for (genvar i = 0; i < LINE_DEPTH; i++) begin : g_entry
    if (i == LINE_DEPTH - 1) begin : g_tail
      assign w_shift[i] = r_mem[i];
    end else begin : g_mid
      assign w_shift[i] = r_mem[i + 1];
    end
    // Each entry either takes the new line, shifts toward the head on a
    // pop, or holds.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_mem[i] <= '0;
      end else if (w_push && (w_wrIdx == 4'(i))) begin
        r_mem[i] <= w_fullLine;
      end else if (w_pop) begin
        r_mem[i] <= w_shift[i];
      end
    end
  end

  // FIFO occupancy: a push and a pop in the same cycle cancel out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_occ <= 4'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 4'd1;
        2'b01:   r_occ <= r_occ - 4'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Outstanding request count, saturating at both ends.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out <= 4'd0;
    end else begin
      case ({reqIssue, w_done})
        2'b10: begin
          if (r_out != 4'hF) r_out <= r_out + 4'd1;
        end
        2'b01: begin
          if (r_out != 4'd0) r_out <= r_out - 4'd1;
        end
        default: r_out <= r_out;
      endcase
    end
  end

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ovf   <= 1'b0;
      r_spur  <= 1'b0;
      r_proto <= 1'b0;
    end else begin
      if (w_done && !w_room)          r_ovf   <= 1'b1;
      if (w_hit && (r_out == 4'd0))   r_spur  <= 1'b1;
      if (reqIssue && !canIssue)      r_proto <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rd_return_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_rd_return_receiver
// Purpose  : Self-checking bench for rd_return_receiver. Directed scenarios
//            plus a randomized run compared against a queue-based model of
//            line assembly, the line FIFO, credits and error flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rd_return_receiver;

  localparam int CORE_ID = 1;
  localparam int WPL     = 8;
  localparam int DEPTH   = 2;
  localparam int LW      = 32 * WPL;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [31:0]    RDreturn = '0;
  logic [3:0]     RDdest = '0;
  logic           reqIssue = 1'b0;
  logic           canIssue;
  logic           lineValid;
  logic [LW-1:0]  lineData;
  logic           lineReady = 1'b0;
  logic [3:0]     outstanding;
  logic           overflow;
  logic           spurious;
  logic           protoErr;

  int nChecks = 0;
  int nPass   = 0;

  // Reference model state
  logic [31:0]    mWords[$];
  logic [LW-1:0]  mFifo[$];
  int             mOut;
  bit             mOvf, mSpur, mProto;

  rd_return_receiver #(
    .CORE_ID(CORE_ID), .WORDS_PER_LINE(WPL), .LINE_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .RDreturn(RDreturn), .RDdest(RDdest),
    .reqIssue(reqIssue), .canIssue(canIssue), .lineValid(lineValid),
    .lineData(lineData), .lineReady(lineReady), .outstanding(outstanding),
    .overflow(overflow), .spurious(spurious), .protoErr(protoErr)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    mWords.delete();
    mFifo.delete();
    mOut = 0; mOvf = 0; mSpur = 0; mProto = 0;
  endtask

  // One clock edge of the model, evaluated from pre-edge state.
  task automatic model_edge(input logic [3:0] dest, input logic [31:0] data,
                            input bit req, input bit rdy);
    bit hit, pop, done, credit;
    logic [LW-1:0] line;
    line   = '0;
    hit    = (dest == 4'(CORE_ID));
    pop    = (mFifo.size() > 0) && rdy;
    credit = (mOut + mFifo.size()) < DEPTH;
    done   = 0;
    if (req && !credit) mProto = 1;
    if (hit && mOut == 0) mSpur = 1;
    if (hit) begin
      mWords.push_back(data);
      if (mWords.size() == WPL) begin
        done = 1;
        for (int k = 0; k < WPL; k++) line[32*k +: 32] = mWords[k];
        mWords.delete();
      end
    end
    if (pop) void'(mFifo.pop_front());
    if (done) begin
      if (mFifo.size() < DEPTH) mFifo.push_back(line);
      else mOvf = 1;
    end
    if (req && !done) mOut = (mOut < 15) ? mOut + 1 : 15;
    else if (done && !req) mOut = (mOut > 0) ? mOut - 1 : 0;
  endtask

  task automatic tick(input logic [3:0] dest, input logic [31:0] data,
                      input bit req, input bit rdy);
    RDdest = dest; RDreturn = data; reqIssue = req; lineReady = rdy;
    model_edge(dest, data, req, rdy);
    @(posedge clock); #1;
    RDdest = 4'd0; reqIssue = 1'b0; lineReady = 1'b0;
  endtask

  task automatic apply_reset();
    #2; reset = 1'b1;
    model_clear();
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic send_line(input logic [31:0] base, input bit rdyLast);
    for (int k = 0; k < WPL; k++)
      tick(4'(CORE_ID), base + 32'(k), 1'b0, (k == WPL-1) ? rdyLast : 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; #2;
    nChecks++; if (lineValid !== 1'b0) $display("FAIL reset_lineValid: got %b want 0", lineValid); else nPass++;
    nChecks++; if (lineData !== '0) $display("FAIL reset_lineData: got %h want 0", lineData); else nPass++;
    nChecks++; if (outstanding !== 4'd0) $display("FAIL reset_outstanding: got %0d want 0", outstanding); else nPass++;
    nChecks++; if (canIssue !== 1'b1) $display("FAIL reset_canIssue: got %b want 1", canIssue); else nPass++;
    nChecks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else nPass++;
    nChecks++; if (spurious !== 1'b0) $display("FAIL reset_spurious: got %b want 0", spurious); else nPass++;
    nChecks++; if (protoErr !== 1'b0) $display("FAIL reset_protoErr: got %b want 0", protoErr); else nPass++;
    model_clear();
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_single_line();
    tick(4'd0, 32'd0, 1'b1, 1'b0);
    nChecks++; if (outstanding !== 4'd1) $display("FAIL single_out1: got %0d want 1", outstanding); else nPass++;
    for (int k = 0; k < WPL; k++) begin
      tick(4'(CORE_ID), 32'h100 + 32'(k), 1'b0, 1'b0);
      if (k == WPL-2) begin
        nChecks++; if (lineValid !== 1'b0) $display("FAIL single_early_valid: got %b want 0", lineValid); else nPass++;
      end
    end
    nChecks++; if (lineValid !== 1'b1) $display("FAIL single_valid: got %b want 1", lineValid); else nPass++;
    nChecks++; if (lineData[31:0] !== 32'h100) $display("FAIL single_word0: got %h want 00000100", lineData[31:0]); else nPass++;
    nChecks++; if (lineData[255:224] !== 32'h107) $display("FAIL single_word7: got %h want 00000107", lineData[255:224]); else nPass++;
    nChecks++; if (outstanding !== 4'd0) $display("FAIL single_out0: got %0d want 0", outstanding); else nPass++;
    tick(4'd0, 32'd0, 1'b0, 1'b1);
    nChecks++; if (lineValid !== 1'b0) $display("FAIL single_pop: got %b want 0", lineValid); else nPass++;
  endtask

  task automatic test_interleaved();
    logic [LW-1:0] exp;
    for (int k = 0; k < WPL; k++) exp[32*k +: 32] = 32'h100 + 32'(k);
    tick(4'd0, 32'd0, 1'b1, 1'b0);
    for (int k = 0; k < WPL; k++) begin
      tick(4'(CORE_ID), 32'h100 + 32'(k), 1'b0, 1'b0);
      tick((k % 2 == 1) ? 4'(CORE_ID + 1) : 4'd0, $urandom, 1'b0, 1'b0);
    end
    nChecks++; if (lineValid !== 1'b1) $display("FAIL inter_valid: got %b want 1", lineValid); else nPass++;
    nChecks++; if (lineData !== exp) $display("FAIL inter_data: got %h want %h", lineData, exp); else nPass++;
    tick(4'd0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic test_credit_limit();
    tick(4'd0, 32'd0, 1'b1, 1'b0);
    nChecks++; if (canIssue !== 1'b1) $display("FAIL credit_one: got %b want 1", canIssue); else nPass++;
    tick(4'd0, 32'd0, 1'b1, 1'b0);
    nChecks++; if (canIssue !== 1'b0) $display("FAIL credit_two: got %b want 0", canIssue); else nPass++;
    send_line(32'hA000, 1'b0);
    send_line(32'hB000, 1'b0);
    nChecks++; if (canIssue !== 1'b0) $display("FAIL credit_full: got %b want 0", canIssue); else nPass++;
    nChecks++; if (outstanding !== 4'd0) $display("FAIL credit_out: got %0d want 0", outstanding); else nPass++;
    tick(4'd0, 32'd0, 1'b0, 1'b1);
    nChecks++; if (canIssue !== 1'b1) $display("FAIL credit_after_pop: got %b want 1", canIssue); else nPass++;
    nChecks++; if (lineData[31:0] !== 32'hB000) $display("FAIL credit_head2: got %h want 0000b000", lineData[31:0]); else nPass++;
    tick(4'd0, 32'd0, 1'b0, 1'b1);
    nChecks++; if (lineValid !== 1'b0) $display("FAIL credit_drain: got %b want 0", lineValid); else nPass++;
  endtask

  task automatic test_overflow();
    apply_reset();
    tick(4'd0, 32'd0, 1'b1, 1'b0);
    tick(4'd0, 32'd0, 1'b1, 1'b0);
    send_line(32'hC000, 1'b0);
    send_line(32'hD000, 1'b0);
    send_line(32'hE000, 1'b0);
    nChecks++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow); else nPass++;
    nChecks++; if (canIssue !== 1'b0) $display("FAIL ovf_occ: canIssue got %b want 0", canIssue); else nPass++;
    nChecks++; if (lineData[31:0] !== 32'hC000 || lineData[255:224] !== 32'hC007)
      $display("FAIL ovf_head: got %h want head line C000..C007", lineData); else nPass++;
    apply_reset();
    tick(4'd0, 32'd0, 1'b1, 1'b0);
    tick(4'd0, 32'd0, 1'b1, 1'b0);
    send_line(32'hC000, 1'b0);
    send_line(32'hD000, 1'b0);
    send_line(32'hE000, 1'b1);
    nChecks++; if (overflow !== 1'b0) $display("FAIL ovf_pop_same: got %b want 0", overflow); else nPass++;
    nChecks++; if (canIssue !== 1'b0) $display("FAIL ovf_pop_occ: canIssue got %b want 0", canIssue); else nPass++;
    nChecks++; if (lineData[31:0] !== 32'hD000) $display("FAIL ovf_pop_head: got %h want 0000d000", lineData[31:0]); else nPass++;
  endtask

  task automatic test_errors();
    apply_reset();
    tick(4'(CORE_ID), $urandom, 1'b0, 1'b0);
    nChecks++; if (spurious !== 1'b1) $display("FAIL err_spurious: got %b want 1", spurious); else nPass++;
    nChecks++; if (protoErr !== 1'b0) $display("FAIL err_proto_early: got %b want 0", protoErr); else nPass++;
    tick(4'd0, 32'd0, 1'b1, 1'b0);
    tick(4'd0, 32'd0, 1'b1, 1'b0);
    tick(4'd0, 32'd0, 1'b1, 1'b0);
    nChecks++; if (protoErr !== 1'b1) $display("FAIL err_proto: got %b want 1", protoErr); else nPass++;
    nChecks++; if (outstanding !== 4'd3) $display("FAIL err_out3: got %0d want 3", outstanding); else nPass++;
    for (int i = 0; i < 5; i++) tick(4'd0, 32'd0, 1'b0, 1'b0);
    nChecks++; if (spurious !== 1'b1 || protoErr !== 1'b1)
      $display("FAIL err_hold: got spurious=%b protoErr=%b want 1 1", spurious, protoErr); else nPass++;
    apply_reset();
    nChecks++; if (spurious !== 1'b0 || protoErr !== 1'b0)
      $display("FAIL err_clear: got spurious=%b protoErr=%b want 0 0", spurious, protoErr); else nPass++;
  endtask

  task automatic test_async_reset_midline();
    logic [LW-1:0] exp;
    for (int k = 0; k < WPL; k++) exp[32*k +: 32] = 32'h200 + 32'(k);
    apply_reset();
    tick(4'd0, 32'd0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) tick(4'(CORE_ID), 32'h900 + 32'(k), 1'b0, 1'b0);
    #2; reset = 1'b1; #1;
    nChecks++; if (outstanding !== 4'd0 || canIssue !== 1'b1 || lineValid !== 1'b0 || lineData !== '0)
      $display("FAIL areset_outputs: got out=%0d can=%b valid=%b data=%h want 0 1 0 0",
               outstanding, canIssue, lineValid, lineData); else nPass++;
    model_clear();
    @(posedge clock); #1;
    reset = 1'b0;
    tick(4'd0, 32'd0, 1'b1, 1'b0);
    send_line(32'h200, 1'b0);
    nChecks++; if (lineValid !== 1'b1) $display("FAIL areset_valid: got %b want 1", lineValid); else nPass++;
    nChecks++; if (lineData !== exp) $display("FAIL areset_data: got %h want %h", lineData, exp); else nPass++;
    tick(4'd0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    int r;
    bit credit, req, rdy, expCan;
    logic [3:0] dest;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45 && (mOut > 0 || $urandom_range(0, 49) == 0)) dest = 4'(CORE_ID);
      else if (r < 65) dest = 4'(CORE_ID + 1 + int'($urandom_range(0, 13)));
      else dest = 4'd0;
      credit = (mOut + mFifo.size()) < DEPTH;
      req = credit ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      tick(dest, $urandom, req, rdy);
      expCan = (mOut + mFifo.size()) < DEPTH;
      nChecks++; if (lineValid !== (mFifo.size() > 0)) $display("FAIL rnd_valid c=%0d: got %b want %b", c, lineValid, mFifo.size() > 0); else nPass++;
      if (mFifo.size() > 0) begin
        nChecks++; if (lineData !== mFifo[0]) $display("FAIL rnd_data c=%0d: got %h want %h", c, lineData, mFifo[0]); else nPass++;
      end
      nChecks++; if (outstanding !== 4'(mOut)) $display("FAIL rnd_out c=%0d: got %0d want %0d", c, outstanding, mOut); else nPass++;
      nChecks++; if (canIssue !== expCan) $display("FAIL rnd_can c=%0d: got %b want %b", c, canIssue, expCan); else nPass++;
      nChecks++; if (overflow !== mOvf) $display("FAIL rnd_ovf c=%0d: got %b want %b", c, overflow, mOvf); else nPass++;
      nChecks++; if (spurious !== mSpur) $display("FAIL rnd_spur c=%0d: got %b want %b", c, spurious, mSpur); else nPass++;
      nChecks++; if (protoErr !== mProto) $display("FAIL rnd_proto c=%0d: got %b want %b", c, protoErr, mProto); else nPass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_interleaved();
    test_credit_limit();
    test_overflow();
    test_errors();
    test_async_reset_midline();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
